// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: shares one AR/R master port between MEM (m0) and IF (m1).
// One burst in flight at a time; round-robin or fixed priority; sticky burst-length error flag.
module axi_rd_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int ID_W       = 4,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   // m0: MEM-stage loads
   input  logic              m0_arvalid,
   output logic              m0_arready,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [7:0]        m0_arlen,
   input  logic [2:0]        m0_arsize,
   input  logic [1:0]        m0_arburst,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [ID_W-1:0]   m0_rid,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   // m1: instruction fetch
   input  logic              m1_arvalid,
   output logic              m1_arready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [7:0]        m1_arlen,
   input  logic [2:0]        m1_arsize,
   input  logic [1:0]        m1_arburst,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ID_W-1:0]   m1_rid,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   // shared master port
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [ID_W-1:0]   s_arid,
   output logic [7:0]        s_arlen,
   output logic [2:0]        s_arsize,
   output logic [1:0]        s_arburst,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [ID_W-1:0]   s_rid,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   output logic              busy_o,
   output logic              owner_o,
   output logic              err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [ID_W-1:0]   arid_q, arid_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [2:0]        arsize_q, arsize_d;
   logic [1:0]        arburst_q, arburst_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic              err_q, err_d;

   logic gnt_any, gnt_m1, in_data, r_hs;

   // Ties go to m0 under fixed priority, otherwise to whoever did not win last time.
   always_comb begin
      gnt_any = (state_q == S_IDLE) && (m0_arvalid || m1_arvalid);
      if (m0_arvalid && m1_arvalid)
         gnt_m1 = (FIXED_PRIO != 0) ? 1'b0 : !owner_q;
      else
         gnt_m1 = m1_arvalid;
   end

   // arready is qualified by rst_n so no grant is visible while reset is asserted.
   assign m0_arready = gnt_any && !gnt_m1 && rst_n;
   assign m1_arready = gnt_any &&  gnt_m1 && rst_n;

   assign in_data = (state_q == S_DATA);
   assign r_hs    = in_data && s_rvalid && s_rready;

   assign s_rready  = in_data && (owner_q ? m1_rready : m0_rready);
   assign m0_rvalid = in_data && !owner_q && s_rvalid;
   assign m1_rvalid = in_data &&  owner_q && s_rvalid;
   assign m0_rdata  = (in_data && !owner_q) ? s_rdata : '0;
   assign m0_rid    = (in_data && !owner_q) ? s_rid   : '0;
   assign m0_rresp  = (in_data && !owner_q) ? s_rresp : '0;
   assign m0_rlast  = in_data && !owner_q && s_rlast;
   assign m1_rdata  = (in_data &&  owner_q) ? s_rdata : '0;
   assign m1_rid    = (in_data &&  owner_q) ? s_rid   : '0;
   assign m1_rresp  = (in_data &&  owner_q) ? s_rresp : '0;
   assign m1_rlast  = in_data &&  owner_q && s_rlast;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      araddr_d   = araddr_q;
      arid_d     = arid_q;
      arlen_d    = arlen_q;
      arsize_d   = arsize_q;
      arburst_d  = arburst_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               state_d   = S_ADDR;
               owner_d   = gnt_m1;
               araddr_d  = gnt_m1 ? m1_araddr  : m0_araddr;
               arid_d    = gnt_m1 ? m1_arid    : m0_arid;
               arlen_d   = gnt_m1 ? m1_arlen   : m0_arlen;
               arsize_d  = gnt_m1 ? m1_arsize  : m0_arsize;
               arburst_d = gnt_m1 ? m1_arburst : m0_arburst;
            end
         end
         S_ADDR: begin
            if (s_arready)
               state_d = S_DATA;
         end
         S_DATA: begin
            if (r_hs) begin
               // The burst always ends at rlast; a length mismatch only flags the error.
               if (s_rlast) begin
                  if (beat_cnt_q != arlen_q)
                     err_d = 1'b1;
                  state_d    = S_IDLE;
                  beat_cnt_d = '0;
               end else begin
                  if (beat_cnt_q == arlen_q)
                     err_d = 1'b1;
                  if (beat_cnt_q != 8'hFF)
                     beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b1;
         araddr_q   <= '0;
         arid_q     <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         arburst_q  <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         araddr_q   <= araddr_d;
         arid_q     <= arid_d;
         arlen_q    <= arlen_d;
         arsize_q   <= arsize_d;
         arburst_q  <= arburst_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign s_arvalid = (state_q == S_ADDR);
   assign s_araddr  = araddr_q;
   assign s_arid    = arid_q;
   assign s_arlen   = arlen_q;
   assign s_arsize  = arsize_q;
   assign s_arburst = arburst_q;
   assign busy_o    = (state_q != S_IDLE);
   assign owner_o   = owner_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: requester/slave traffic checked against a transaction-level model.
module tb_axi_rd_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [63:0] m0_araddr, m0_rdata;
   logic [3:0]  m0_arid, m0_rid;
   logic [7:0]  m0_arlen;
   logic [2:0]  m0_arsize;
   logic [1:0]  m0_arburst, m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [63:0] m1_araddr, m1_rdata;
   logic [3:0]  m1_arid, m1_rid;
   logic [7:0]  m1_arlen;
   logic [2:0]  m1_arsize;
   logic [1:0]  m1_arburst, m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [63:0] s_araddr, s_rdata;
   logic [3:0]  s_arid, s_rid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst, s_rresp;
   logic        busy, owner, err;

   // fixed-priority instance: own handshakes, shares the payload inputs
   logic        f_m0_arvalid, f_m0_arready, f_m0_rvalid, f_m0_rready, f_m0_rlast;
   logic        f_m1_arvalid, f_m1_arready, f_m1_rvalid, f_m1_rready, f_m1_rlast;
   logic [63:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
   logic [3:0]  f_m0_rid, f_m1_rid, f_s_arid;
   logic [1:0]  f_m0_rresp, f_m1_rresp, f_s_arburst;
   logic        f_s_arvalid, f_s_arready, f_s_rvalid, f_s_rready, f_s_rlast;
   logic [7:0]  f_s_arlen;
   logic [2:0]  f_s_arsize;
   logic        f_busy, f_owner, f_err;

   axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
      .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rid(m0_rid),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
      .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rid(m1_rid),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .busy_o(busy), .owner_o(owner), .err_o(err)
   );

   axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_arvalid(f_m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
      .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(f_m0_rvalid), .m0_rready(f_m0_rready), .m0_rdata(f_m0_rdata), .m0_rid(f_m0_rid),
      .m0_rresp(f_m0_rresp), .m0_rlast(f_m0_rlast),
      .m1_arvalid(f_m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
      .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(f_m1_rvalid), .m1_rready(f_m1_rready), .m1_rdata(f_m1_rdata), .m1_rid(f_m1_rid),
      .m1_rresp(f_m1_rresp), .m1_rlast(f_m1_rlast),
      .s_arvalid(f_s_arvalid), .s_arready(f_s_arready), .s_araddr(f_s_araddr), .s_arid(f_s_arid),
      .s_arlen(f_s_arlen), .s_arsize(f_s_arsize), .s_arburst(f_s_arburst),
      .s_rvalid(f_s_rvalid), .s_rready(f_s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
      .s_rresp(s_rresp), .s_rlast(f_s_rlast),
      .busy_o(f_busy), .owner_o(f_owner), .err_o(f_err)
   );

   int checks = 0;
   int errors = 0;
   int burst_no = 0;

   // model state: pending requests per requester, last winner, expected sticky error
   bit          pend [2];
   logic [63:0] p_addr [2];
   logic [3:0]  p_id [2];
   logic [7:0]  p_len [2];
   logic [2:0]  p_size [2];
   logic [1:0]  p_burst [2];
   int          last_owner;
   bit          err_exp;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic new_req(input int i);
      pend[i]    = 1'b1;
      p_addr[i]  = {$urandom, $urandom};
      p_id[i]    = 4'($urandom_range(0, 15));
      p_len[i]   = 8'($urandom_range(0, 4));
      p_size[i]  = 3'($urandom_range(0, 7));
      p_burst[i] = 2'($urandom_range(0, 2));
   endtask

   task automatic drive_reqs();
      m0_arvalid = pend[0]; m0_araddr = p_addr[0]; m0_arid = p_id[0];
      m0_arlen = p_len[0]; m0_arsize = p_size[0]; m0_arburst = p_burst[0];
      m1_arvalid = pend[1]; m1_araddr = p_addr[1]; m1_arid = p_id[1];
      m1_arlen = p_len[1]; m1_arsize = p_size[1]; m1_arburst = p_burst[1];
   endtask

   task automatic set_rready(input int w, input logic rdy);
      if (w == 0) begin m0_rready = rdy; m1_rready = 1'($urandom_range(0, 1)); end
      else        begin m1_rready = rdy; m0_rready = 1'($urandom_range(0, 1)); end
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_owner"}, owner, 1);
      chk({pfx, "_err"}, err, 0);
      chk({pfx, "_s_arvalid"}, s_arvalid, 0);
      chk({pfx, "_s_araddr"}, s_araddr, 0);
      chk({pfx, "_s_arlen"}, s_arlen, 0);
      chk({pfx, "_s_rready"}, s_rready, 0);
      chk({pfx, "_rvalid"}, {m0_rvalid, m1_rvalid}, 0);
      chk({pfx, "_arready"}, {m0_arready, m1_arready}, 0);
   endtask

   // One arbitration + address + data phase. nb_force>0 overrides the beat count;
   // rst_beat>=0 asserts reset just before that beat and abandons the burst.
   task automatic do_burst(input int nwait, input int rst_beat, input int nb_force,
                           input bit allow_err, input bit add_new);
      int w, nb, tries;
      logic [63:0] g_addr, d;
      logic [7:0]  g_len;
      logic [3:0]  g_id, rid;
      logic [2:0]  g_size;
      logic [1:0]  g_burst, rsp;
      logic        rdy, lst;
      if (add_new) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
         if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      end
      if (pend[0] && pend[1]) w = (last_owner == 0) ? 1 : 0;
      else                    w = pend[1] ? 1 : 0;
      // grant cycle (also the idle bubble after the previous burst)
      @(negedge clk);
      drive_reqs();
      s_arready = 0; s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
      #1;
      chk("idle_busy", busy, 0);
      chk("grant_m0", m0_arready, (w == 0));
      chk("grant_m1", m1_arready, (w == 1));
      chk("err_sticky", err, err_exp);
      g_addr = p_addr[w]; g_id = p_id[w]; g_len = p_len[w]; g_size = p_size[w]; g_burst = p_burst[w];
      pend[w] = 1'b0;
      last_owner = w;
      // address phase: stable request until accepted, no new grants
      for (int c = 0; c <= nwait; c++) begin
         @(negedge clk);
         if (add_new && !pend[w] && $urandom_range(0, 3) == 0) new_req(w);
         drive_reqs();
         s_arready = (c == nwait);
         #1;
         chk("s_arvalid", s_arvalid, 1);
         chk("s_araddr", s_araddr, g_addr);
         chk("s_ar_misc", {s_arid, s_arlen, s_arsize, s_arburst}, {g_id, g_len, g_size, g_burst});
         chk("owner", owner, w);
         chk("no_arready_addr", {m0_arready, m1_arready}, 0);
      end
      if (nb_force > 0)                                nb = nb_force;
      else if (allow_err && $urandom_range(0, 5) == 0) nb = int'($urandom_range(1, int'(g_len) + 2));
      else                                             nb = int'(g_len) + 1;
      if (nb - 1 != int'(g_len)) err_exp = 1'b1;
      $display("burst %0d owner m%0d addr %h len %0d beats %0d wait %0d", burst_no, w, g_addr, g_len, nb, nwait);
      burst_no++;
      for (int k = 0; k < nb; k++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            @(negedge clk);
            drive_reqs();
            s_arready = 0; s_rvalid = 0;
            rdy = 1'($urandom_range(0, 1));
            set_rready(w, rdy);
            #1;
            chk("gap_rvalid", {m0_rvalid, m1_rvalid}, 0);
            chk("gap_busy", busy, 1);
            chk("gap_rready", s_rready, rdy);
         end
         if (k == rst_beat) begin
            @(negedge clk);
            rst_n = 0;
            #1;
            check_reset_outputs("mid_rst");
            last_owner = 1;
            err_exp = 1'b0;
            s_rvalid = 0; s_arready = 0;
            repeat (2) @(negedge clk);
            rst_n = 1;
            return;
         end
         d = {$urandom, $urandom};
         rid = 4'($urandom_range(0, 15));
         rsp = 2'($urandom_range(0, 3));
         lst = (k == nb - 1);
         tries = 0;
         do begin
            @(negedge clk);
            drive_reqs();
            s_arready = 0; s_rvalid = 1; s_rdata = d; s_rid = rid; s_rresp = rsp; s_rlast = lst;
            rdy = (tries >= 3) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            set_rready(w, rdy);
            tries++;
            #1;
            if (w == 0) begin
               chk("m0_rvalid", m0_rvalid, 1);
               chk("m0_rdata", m0_rdata, d);
               chk("m0_rmisc", {m0_rid, m0_rresp, m0_rlast}, {rid, rsp, lst});
               chk("m1_rvalid_idle", m1_rvalid, 0);
            end else begin
               chk("m1_rvalid", m1_rvalid, 1);
               chk("m1_rdata", m1_rdata, d);
               chk("m1_rmisc", {m1_rid, m1_rresp, m1_rlast}, {rid, rsp, lst});
               chk("m0_rvalid_idle", m0_rvalid, 0);
            end
            chk("s_rready", s_rready, rdy);
            chk("no_arready_data", {m0_arready, m1_arready}, 0);
         end while (!rdy);
      end
   endtask

   initial begin
      rst_n = 0;
      pend[0] = 0; pend[1] = 0;
      for (int i = 0; i < 2; i++) begin
         p_addr[i] = '0; p_id[i] = '0; p_len[i] = '0; p_size[i] = '0; p_burst[i] = '0;
      end
      drive_reqs();
      m0_rready = 0; m1_rready = 0;
      s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 0;
      f_m0_arvalid = 0; f_m1_arvalid = 0; f_m0_rready = 0; f_m1_rready = 0;
      f_s_arready = 0; f_s_rvalid = 0; f_s_rlast = 0;
      last_owner = 1;
      err_exp = 0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1;

      // m1 alone, single beat
      new_req(1);
      p_addr[1] = 64'h0000_0000_8000_0000;
      p_len[1] = 0;
      do_burst(0, -1, 0, 0, 0);
      // simultaneous requests, held: m0 then m1
      new_req(0); new_req(1);
      do_burst(0, -1, 0, 0, 0);
      do_burst(0, -1, 0, 0, 0);
      // long address stall
      new_req(0);
      do_burst(10, -1, 0, 0, 0);
      // clean random traffic
      for (int n = 0; n < 40; n++) do_burst(int'($urandom_range(0, 3)), -1, 0, 0, 1);
      // len 3 terminated early by rlast on beat 1
      pend[0] = 0; pend[1] = 0;
      new_req(0);
      p_len[0] = 3;
      do_burst(0, -1, 2, 0, 0);
      // random traffic including length errors
      for (int n = 0; n < 20; n++) do_burst(int'($urandom_range(0, 3)), -1, 0, 1, 1);
      // reset during beat 2 of a 4-beat burst
      pend[0] = 0; pend[1] = 0;
      new_req(1);
      p_len[1] = 3;
      do_burst(0, 2, 0, 0, 0);
      // after reset the tie goes to m0; len 0 with an extra beat before rlast
      new_req(0); new_req(1);
      p_len[0] = 0;
      do_burst(0, -1, 2, 0, 0);
      do_burst(1, -1, 0, 0, 0);
      @(negedge clk);
      pend[0] = 0; pend[1] = 0;
      drive_reqs();
      s_rvalid = 0; s_rlast = 0;
      #1;
      chk("final_err", err, err_exp);
      chk("final_busy", busy, 0);

      // fixed priority: m0 wins every tie while both are held
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         f_m0_arvalid = 1; f_m1_arvalid = 1; f_s_arready = 0; f_s_rvalid = 0; f_s_rlast = 0;
         #1;
         chk("fp_grant_m0", {f_m0_arready, f_m1_arready}, 2'b10);
         @(negedge clk);
         f_s_arready = 1;
         #1;
         chk("fp_owner", f_owner, 0);
         chk("fp_s_arvalid", f_s_arvalid, 1);
         @(negedge clk);
         f_s_arready = 0; f_s_rvalid = 1; f_s_rlast = 1; f_m0_rready = 1;
         #1;
         chk("fp_m0_rvalid", f_m0_rvalid, 1);
         $display("fp burst %0d owner m0", r);
      end
      @(negedge clk);
      f_m0_arvalid = 0; f_m1_arvalid = 1; f_s_rvalid = 0; f_s_rlast = 0; f_m0_rready = 0;
      #1;
      chk("fp_grant_m1", {f_m0_arready, f_m1_arready}, 2'b01);
      @(negedge clk);
      f_m1_arvalid = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
